// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU memory-port logic.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    // Requester identifiers used for grants and the last-served record
    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DM = 1'b1;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, grants the requester not served last.
module rr_pick2
    import cpu_pkg::*;
(
    input  logic i_req_if,
    input  logic i_req_dm,
    input  logic i_last,
    output logic o_grant
);

    always_comb begin
        if (i_req_if && i_req_dm) begin
            o_grant = (i_last == REQ_IF) ? REQ_DM : REQ_IF;
        end else if (i_req_dm) begin
            o_grant = REQ_DM;
        end else begin
            o_grant = REQ_IF;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and data memory,
// one transaction at a time, with an optional ready timeout.
module mem_port_arbiter
    import cpu_pkg::*;
#(
    parameter int          AW      = DEF_AW,
    parameter int          DW      = DEF_DW,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          cpu_clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_done,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_done,
    output logic [DW-1:0] dm_rdata,
    output logic          bus_err,
    output logic          bus_valid,
    output logic          bus_we,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_ready,
    input  logic [DW-1:0] bus_rdata
);

    localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    arb_state_t    r_state, w_state_nxt;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic          r_if_done, r_dm_done, r_bus_err, r_bus_valid, r_bus_we;
    logic [DW-1:0] r_if_rdata, r_dm_rdata, r_bus_wdata;
    logic [AW-1:0] r_bus_addr;

    logic w_if_elig, w_dm_elig, w_grant_id, w_busy, w_complete, w_abort;

    // A requester is masked in its own done cycle so it cannot be re-granted back-to-back
    assign w_if_elig = if_req && !r_if_done;
    assign w_dm_elig = dm_req && !r_dm_done;

    rr_pick2 u_pick (
        .i_req_if (w_if_elig),
        .i_req_dm (w_dm_elig),
        .i_last   (r_last),
        .o_grant  (w_grant_id)
    );

    always_comb begin
        w_busy      = (r_state != IDLE);
        w_complete  = w_busy && bus_ready;
        w_abort     = w_busy && !bus_ready && TMO_EN && (r_cnt == CNT_LAST);
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_if_elig || w_dm_elig) begin
                    w_state_nxt = (w_grant_id == REQ_DM) ? BUSY_DM : BUSY_IF;
                end
            end
            default: begin
                if (w_complete || w_abort) begin
                    w_state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last      <= REQ_IF;
            r_cnt       <= '0;
            r_if_done   <= 1'b0;
            r_dm_done   <= 1'b0;
            r_bus_err   <= 1'b0;
            r_bus_valid <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            r_bus_err <= 1'b0;
            if (r_state == IDLE) begin
                if (w_state_nxt != IDLE) begin
                    r_bus_valid <= 1'b1;
                    r_cnt       <= '0;
                    if (w_grant_id == REQ_DM) begin
                        r_bus_we    <= dm_we;
                        r_bus_addr  <= dm_addr;
                        r_bus_wdata <= dm_wdata;
                    end else begin
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= '0;
                    end
                end
            end else if (w_complete) begin
                r_bus_valid <= 1'b0;
                if (r_state == BUSY_DM) begin
                    r_last    <= REQ_DM;
                    r_dm_done <= 1'b1;
                    if (!r_bus_we) begin
                        r_dm_rdata <= bus_rdata;
                    end
                end else begin
                    r_last     <= REQ_IF;
                    r_if_done  <= 1'b1;
                    r_if_rdata <= bus_rdata;
                end
            end else if (w_abort) begin
                r_bus_valid <= 1'b0;
                r_bus_err   <= 1'b1;
                if (r_state == BUSY_DM) begin
                    r_dm_done  <= 1'b1;
                    r_dm_rdata <= '0;
                end else begin
                    r_if_done  <= 1'b1;
                    r_if_rdata <= '0;
                end
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign if_done   = r_if_done;
    assign if_rdata  = r_if_rdata;
    assign dm_done   = r_dm_done;
    assign dm_rdata  = r_dm_rdata;
    assign bus_err   = r_bus_err;
    assign bus_valid = r_bus_valid;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed scenarios.
module tb_mem_port_arbiter;

    localparam int          AW    = 32;
    localparam int          DW    = 32;
    localparam int unsigned TMO   = 4;
    localparam int          ID_IF = 1;
    localparam int          ID_DM = 2;

    logic          cpu_clk = 1'b0;
    logic          reset   = 1'b0;
    logic          if_req  = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          dm_req  = 1'b0;
    logic          dm_we   = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic          bus_ready = 1'b0;
    logic [DW-1:0] bus_rdata = '0;
    logic          if_done, dm_done, bus_err, bus_valid, bus_we;
    logic [DW-1:0] if_rdata, dm_rdata, bus_wdata;
    logic [AW-1:0] bus_addr;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TMO)) dut (
        .cpu_clk   (cpu_clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .bus_err   (bus_err),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ready (bus_ready),
        .bus_rdata (bus_rdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction-level model: who owns the bus, how long it has stalled, who was served last
    int          m_owner = 0;
    int          m_stall = 0;
    int          m_last  = ID_IF;
    logic        m_if_done = 1'b0, m_dm_done = 1'b0, m_err = 1'b0, m_valid = 1'b0, m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
    int          m_log[$];

    always @(posedge cpu_clk) begin
        logic prev_if, prev_dm, e_if, e_dm;
        int   pick;
        cyc++;
        prev_if   = m_if_done;
        prev_dm   = m_dm_done;
        m_if_done = 1'b0;
        m_dm_done = 1'b0;
        m_err     = 1'b0;
        if (!reset) begin
            m_owner = 0; m_stall = 0; m_last = ID_IF; m_valid = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
        end else if (m_owner == 0) begin
            e_if = if_req && !prev_if;
            e_dm = dm_req && !prev_dm;
            if (e_if && e_dm)  pick = (m_last == ID_IF) ? ID_DM : ID_IF;
            else if (e_dm)     pick = ID_DM;
            else if (e_if)     pick = ID_IF;
            else               pick = 0;
            if (pick != 0) begin
                m_owner = pick;
                m_stall = 0;
                m_valid = 1'b1;
                m_log.push_back(pick);
                if (pick == ID_DM) begin
                    m_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                end else begin
                    m_we = 1'b0; m_addr = if_addr;
                end
            end
        end else if (bus_ready) begin
            if (m_owner == ID_IF) begin
                m_if_done  = 1'b1;
                m_if_rdata = bus_rdata;
            end else begin
                m_dm_done = 1'b1;
                if (!m_we) m_dm_rdata = bus_rdata;
            end
            m_last  = m_owner;
            m_owner = 0;
            m_valid = 1'b0;
        end else begin
            m_stall++;
            if (TMO != 0 && m_stall >= int'(TMO)) begin
                m_err = 1'b1;
                if (m_owner == ID_IF) begin
                    m_if_done = 1'b1; m_if_rdata = '0;
                end else begin
                    m_dm_done = 1'b1; m_dm_rdata = '0;
                end
                m_owner = 0;
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge cpu_clk);
            #1;
            check("if_done",   32'(if_done),   32'(m_if_done));
            check("dm_done",   32'(dm_done),   32'(m_dm_done));
            check("bus_err",   32'(bus_err),   32'(m_err));
            check("bus_valid", 32'(bus_valid), 32'(m_valid));
            check("if_rdata",  if_rdata,       m_if_rdata);
            check("dm_rdata",  dm_rdata,       m_dm_rdata);
            if (m_valid) begin
                check("bus_we",    32'(bus_we), 32'(m_we));
                check("bus_addr",  bus_addr,    m_addr);
                if (m_we) check("bus_wdata", bus_wdata, m_wdata);
            end
        end
    end

    task automatic wait_done(input bit dm, input int max);
        int waited = 0;
        while ((dm ? dm_done : if_done) !== 1'b1) begin
            if (waited >= max) begin
                n_vec++;
                n_err++;
                $display("FAIL %s_wait: no done pulse within %0d cycles (cycle %0d)",
                         dm ? "dm" : "if", max, cyc);
                return;
            end
            @(negedge cpu_clk);
            waited++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g[$];
        int exp_g[4];
        logic prev_v;
        int t0, nvalid;
        exp_g = '{ID_DM, ID_IF, ID_DM, ID_IF};

        // Reset with both requests pending
        if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0;
        bus_ready = 1'b1; bus_rdata = 32'h0BADF00D;
        repeat (3) @(negedge cpu_clk);
        check("rst_if_done",   32'(if_done),   32'h0);
        check("rst_dm_done",   32'(dm_done),   32'h0);
        check("rst_bus_err",   32'(bus_err),   32'h0);
        check("rst_bus_valid", 32'(bus_valid), 32'h0);
        check("rst_bus_we",    32'(bus_we),    32'h0);
        check("rst_bus_addr",  bus_addr,       32'h0);
        check("rst_bus_wdata", bus_wdata,      32'h0);
        check("rst_if_rdata",  if_rdata,       32'h0);
        check("rst_dm_rdata",  dm_rdata,       32'h0);
        reset = 1'b1;

        // Contention: both held, zero-wait bus
        prev_v = 1'b0;
        for (int i = 0; i < 12 && g.size() < 4; i++) begin
            @(negedge cpu_clk);
            if (bus_valid && !prev_v) g.push_back((bus_addr == 32'h200) ? ID_DM : ID_IF);
            prev_v = bus_valid;
        end
        check("grant_count", 32'(g.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < g.size()) check($sformatf("grant[%0d]", i), 32'(g[i]), 32'(exp_g[i]));
            if (i < m_log.size()) check($sformatf("model_grant[%0d]", i), 32'(m_log[i]), 32'(exp_g[i]));
        end
        wait_done(1'b0, 4);
        if_req = 1'b0; dm_req = 1'b0;
        check("cont_if_rdata", if_rdata, 32'h0BADF00D);
        check("cont_dm_rdata", dm_rdata, 32'h0BADF00D);

        // Single fetch, ready already high on the first valid cycle
        @(negedge cpu_clk);
        if_req = 1'b1; if_addr = 32'h100; bus_rdata = 32'hDEADBEEF; bus_ready = 1'b1;
        t0 = cyc;
        @(negedge cpu_clk);
        check("fetch_valid", 32'(bus_valid), 32'h1);
        check("fetch_addr",  bus_addr,       32'h100);
        check("fetch_we",    32'(bus_we),    32'h0);
        wait_done(1'b0, 5);
        check("fetch_latency", 32'(cyc - t0), 32'd2);
        check("fetch_rdata",   if_rdata,      32'hDEADBEEF);
        if_req = 1'b0; bus_ready = 1'b0;

        // Write with three wait cycles
        @(negedge cpu_clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234; bus_rdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            check("wr_valid", 32'(bus_valid), 32'h1);
            check("wr_addr",  bus_addr,       32'h40);
            check("wr_we",    32'(bus_we),    32'h1);
            check("wr_wdata", bus_wdata,      32'h1234);
            if (i == 2) begin
                bus_ready = 1'b1;
                t0 = cyc;
            end
        end
        wait_done(1'b1, 4);
        check("wr_done_delay", 32'(cyc - t0), 32'd1);
        check("wr_rdata_kept", dm_rdata,      32'h0BADF00D);
        check("wr_no_err",     32'(bus_err),  32'h0);
        dm_req = 1'b0; dm_we = 1'b0; bus_ready = 1'b0;

        // Timeout on a read that never sees ready
        @(negedge cpu_clk);
        dm_req = 1'b1; dm_addr = 32'h80; bus_rdata = 32'h11111111;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge cpu_clk);
            if (dm_done) break;
            if (bus_valid) nvalid++;
        end
        check("tmo_valid_cycles", 32'(nvalid),    32'd4);
        check("tmo_done",         32'(dm_done),   32'h1);
        check("tmo_err",          32'(bus_err),   32'h1);
        check("tmo_rdata",        dm_rdata,       32'h0);
        check("tmo_valid_low",    32'(bus_valid), 32'h0);
        dm_req = 1'b0;

        // Reset during a stalled fetch
        @(negedge cpu_clk);
        if_req = 1'b1; if_addr = 32'h300;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        check("midrst_valid_before", 32'(bus_valid), 32'h1);
        reset = 1'b0; if_req = 1'b0;
        @(negedge cpu_clk);
        check("midrst_valid_after", 32'(bus_valid), 32'h0);
        check("midrst_no_done",     32'(if_done),   32'h0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge cpu_clk);
            check("post_rst_valid",   32'(bus_valid), 32'h0);
            check("post_rst_if_done", 32'(if_done),   32'h0);
            check("post_rst_rdata",   if_rdata,       32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single memory bus port of the multicycle CPU between the instruction-fetch requester (IF stage) and the data-memory requester (MEM stage). It accepts one transaction at a time, drives a valid/ready bus handshake, returns read data with a one-cycle done pulse, and aborts hung transactions with an error after a programmable timeout. The stage sequencer holds the owning stage clock until the corresponding done pulse.

## Interface
- AW, 32: address width
- DW, 32: data width
- TIMEOUT, 64: bus cycles to wait for ready before abort; 0 disables the timeout
- cpu_clk  in  1  sole clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request, held until if_done
- if_addr  in  AW  fetch address, stable while if_req
- if_done  out  1  one-cycle pulse, transaction finished
- if_rdata  out  DW  fetched word, valid in the if_done cycle and held until next if_done
- dm_req  in  1  data request, held until dm_done
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  AW  data address
- dm_wdata  in  DW  write data
- dm_done  out  1  one-cycle pulse
- dm_rdata  out  DW  read data, same validity rule as if_rdata
- bus_err  out  1  high in the done cycle of a timed-out transaction
- bus_valid  out  1  bus request
- bus_we  out  1  bus write strobe
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_ready  in  1  bus accepts/completes in this cycle
- bus_rdata  in  DW  read data, sampled when bus_valid && bus_ready

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE: evaluate eligible requests. A requester whose done is high in this cycle is masked.
  - One eligible request: go to BUSY of that requester.
  - Both eligible: round-robin. Serve the requester not served last. After reset, last = IF, so DM wins the first tie.
- On the grant edge, register address, we (forced 0 for IF), and wdata into the bus_* outputs. Set bus_valid = 1. Clear the timeout counter.
- BUSY_x with bus_ready = 1:
  - Capture bus_rdata into x_rdata (left unchanged for writes).
  - Pulse x_done next cycle and return to IDLE.
  - Set bus_valid = 0 and update last = x.
- BUSY_x with bus_ready = 0: increment the counter.
- Timeout: if TIMEOUT != 0 and the counter reaches TIMEOUT-1 with ready still low:
  - Return to IDLE and drop bus_valid.
  - Pulse x_done with bus_err = 1 and x_rdata = 0.
- Requester inputs are ignored while in BUSY. Requesters must keep req/addr/data stable until done.
- Counter width: $clog2(TIMEOUT+1), saturating; no wrap.

## Timing
- Reset (reset = 0 at an edge): all outputs are 0, including rdata registers. state = IDLE, last = IF, counter = 0.
- Reset mid-transaction: bus_valid drops at the next edge. The transaction is discarded and no done is produced.
- Latency: req high in IDLE at cycle 0 → bus_valid at cycle 1 → ready at cycle k≥1 → done and bus_valid = 0 at cycle k+1. Minimum 2 cycles request-to-done.
- Back-to-back:
  - The next transaction can be granted in the cycle done is high (IDLE), but only for the other requester.
  - The same requester is re-granted no earlier than one cycle after its done.
- bus_* outputs are registered and stable for the whole BUSY phase.
- bus_ready while not BUSY is ignored.
- Timeout with TIMEOUT = 1 aborts in the first BUSY cycle if ready is low.

## Structure
- Shared package `cpu_pkg`: state enum (IDLE/BUSY_IF/BUSY_DM), requester-id constants (REQ_IF, REQ_DM), default AW/DW.
- One natural sub-module: `rr_pick2`, a two-way round-robin picker. Inputs: two requests, last-served id. Output: grant id.
- All state, counter, and output registers live in the top.

## Test plan
- Reset: hold reset = 0 for 3 cycles with both reqs high → all outputs 0. After release, DM is granted first.
- Single fetch: if_req, if_addr = 0x100, ready on the first valid cycle, bus_rdata = 0xDEADBEEF → bus_addr = 0x100, bus_we = 0, if_done 2 cycles after req, if_rdata = 0xDEADBEEF.
- Write with wait states: dm_we = 1, dm_addr = 0x40, dm_wdata = 0x1234, ready after 3 cycles → bus_* stable for 3 cycles, dm_done one cycle after ready, dm_rdata unchanged.
- Contention: both reqs held continuously → grants alternate DM, IF, DM, IF. No requester is served twice in a row.
- Timeout: TIMEOUT = 4, ready never asserted → bus_valid high for 4 cycles, then done with bus_err = 1 and rdata = 0.
- Reset mid-BUSY: reset = 0 during cycle 2 of a stalled transaction → bus_valid = 0 next cycle, no done pulse, IDLE afterwards.
